// File: rtl/issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// issue_ctrl_pkg
//
// Shared definitions for the in-order issue controller:
//   - ALU opcode constants (J, JR, JALR, BEQ, BLE) and the bubble opcode
//   - register address width (6) and PC width (14)
//   - FSM state enum for the issue sequencer
//   - helper that classifies ops whose outcome is resolved in the ALU
// ---------------------------------------------------------------------------
package issue_ctrl_pkg;

    localparam int OPE_W    = 6;
    localparam int REG_AW   = 6;
    localparam int PC_W     = 14;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef logic [OPE_W-1:0]  ope_t;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [PC_W-1:0]   pc_t;

    localparam ope_t OPE_J    = 6'b000010;
    localparam ope_t OPE_JR   = 6'b001010;
    localparam ope_t OPE_JALR = 6'b001110;
    localparam ope_t OPE_BEQ  = 6'b010010;
    localparam ope_t OPE_BLE  = 6'b011010;

    // A bubble is presented to the ALU as a plain J: it has no destination
    // and, because it is not in the ALU-resolved set, it never arms a redirect.
    localparam ope_t OPE_BUBBLE = OPE_J;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Ops whose taken/not-taken decision comes back from the ALU one cycle
    // after issue through alu_b_is_hazard.
    function automatic logic is_alu_branch(input ope_t ope);
        return (ope == OPE_JR) || (ope == OPE_JALR) ||
               (ope == OPE_BEQ) || (ope == OPE_BLE);
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// issue_ctrl_if
//
// Bundles every decode / ALU / long-unit / fetch signal of the issue
// controller. clk and rstn stay plain module ports.
//
//   decode   : dec_valid, dec_ope, dec_ds, dec_dt, dec_dd, dec_uses_ds,
//              dec_uses_dt, dec_long  -> controller ; dec_ready <- controller
//   issue    : issue_valid, issue_ope, issue_dd, fwd_ds_sel, fwd_dt_sel
//   alu      : alu_b_is_hazard, alu_b_addr (taken-branch flag and target)
//   long unit: done_valid, done_addr (writeback of a long-latency op)
//   fetch    : redirect_valid, redirect_addr, flush
//
// Modports:
//   master : the surrounding pipeline (drives decode/ALU/long-unit inputs)
//   slave  : the issue controller itself
// ---------------------------------------------------------------------------
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    // decode side
    logic      dec_valid;
    ope_t      dec_ope;
    reg_addr_t dec_ds;
    reg_addr_t dec_dt;
    reg_addr_t dec_dd;
    logic      dec_uses_ds;
    logic      dec_uses_dt;
    logic      dec_long;
    logic      dec_ready;

    // issue side
    logic      issue_valid;
    ope_t      issue_ope;
    reg_addr_t issue_dd;
    logic      fwd_ds_sel;
    logic      fwd_dt_sel;

    // ALU branch resolution
    logic      alu_b_is_hazard;
    pc_t       alu_b_addr;

    // long-latency writeback
    logic      done_valid;
    reg_addr_t done_addr;

    // fetch control
    logic      redirect_valid;
    pc_t       redirect_addr;
    logic      flush;

    modport master (
        output dec_valid, dec_ope, dec_ds, dec_dt, dec_dd,
               dec_uses_ds, dec_uses_dt, dec_long,
               alu_b_is_hazard, alu_b_addr, done_valid, done_addr,
        input  dec_ready, issue_valid, issue_ope, issue_dd,
               fwd_ds_sel, fwd_dt_sel, redirect_valid, redirect_addr, flush
    );

    modport slave (
        input  dec_valid, dec_ope, dec_ds, dec_dt, dec_dd,
               dec_uses_ds, dec_uses_dt, dec_long,
               alu_b_is_hazard, alu_b_addr, done_valid, done_addr,
        output dec_ready, issue_valid, issue_ope, issue_dd,
               fwd_ds_sel, fwd_dt_sel, redirect_valid, redirect_addr, flush
    );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// scoreboard
//
// Tracks registers awaiting a long-latency result and the number of
// long-latency ops outstanding.
//
// Parameters:
//   MAX_LONG   : outstanding long ops allowed (1..15)
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   long_issue : a long op is issued this cycle
//   long_dd    : its destination (0 = none, never marked pending)
//   done_valid : a long unit writes back this cycle
//   done_addr  : register written by that writeback
//   ds/dt/dd_addr : lookup addresses from decode
//   ds/dt/dd_pend : lookup results, with this cycle's writeback already
//                   removed so a dependant can issue alongside its producer's
//                   writeback
//   long_full  : no further long op may issue this cycle
// ---------------------------------------------------------------------------
module scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int MAX_LONG = 4
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      long_issue,
    input  reg_addr_t long_dd,
    input  logic      done_valid,
    input  reg_addr_t done_addr,
    input  reg_addr_t ds_addr,
    input  reg_addr_t dt_addr,
    input  reg_addr_t dd_addr,
    output logic      ds_pend,
    output logic      dt_pend,
    output logic      dd_pend,
    output logic      long_full
);

    logic [NUM_REGS-1:0] pend_reg;
    logic [NUM_REGS-1:0] pend_next;
    logic [NUM_REGS-1:0] pend_eff;   // pend_reg with this cycle's writeback removed

    logic [3:0] lcnt_reg;
    logic [3:0] lcnt_next;
    logic [3:0] lcnt_eff;
    logic       lcnt_dec;

    // Per-register bit: clear first, then set, so a set and a clear of the
    // same register in one cycle leaves it pending. Register 0 is hardwired
    // clear because address 0 means "no register".
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pend_eff[gi]  = 1'b0;
                assign pend_next[gi] = 1'b0;
            end else begin : g_reg
                assign pend_eff[gi]  = pend_reg[gi] &
                                       ~(done_valid && (done_addr == REG_AW'(gi)));
                assign pend_next[gi] = pend_eff[gi] |
                                       (long_issue && (long_dd == REG_AW'(gi)));
            end
        end
    endgenerate

    // The counter saturates at zero: a writeback from an op issued before a
    // reset must not wrap it.
    assign lcnt_dec  = done_valid && (lcnt_reg != 4'd0);
    assign lcnt_eff  = lcnt_reg - {3'b000, lcnt_dec};
    assign lcnt_next = lcnt_eff + {3'b000, long_issue};

    assign long_full = (lcnt_eff >= 4'(MAX_LONG));

    assign ds_pend = pend_eff[ds_addr];
    assign dt_pend = pend_eff[dt_addr];
    assign dd_pend = pend_eff[dd_addr];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_reg <= '0;
            lcnt_reg <= '0;
        end else begin
            pend_reg <= pend_next;
            lcnt_reg <= lcnt_next;
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_ctrl
//
// In-order issue controller between decode and the single-cycle integer
// ALU. Issues at most one instruction per cycle, holds RAW/WAW hazards on
// long-latency results through the scoreboard, steers ALU result forwarding,
// and turns a resolved ALU branch into a redirect followed by a flush
// window. Whenever nothing issues a clean bubble (J, dd=0) is presented.
//
// Parameters:
//   FLUSH_CYCLES : cycles decode is held after a redirect (1..7)
//   MAX_LONG     : outstanding long-latency ops allowed (1..15)
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : issue_ctrl_if.slave -- decode, issue, ALU branch, long-unit
//          writeback and fetch redirect/flush signals
//
// Build option:
//   ISSUE_FWD_EN defined   : back-to-back ALU dependants issue with the
//                            fwd_*_sel steering the ALU result register.
//   ISSUE_FWD_EN undefined : fwd_*_sel are 0 and a dependant on the previous
//                            ALU op waits exactly one bubble instead.
// ---------------------------------------------------------------------------
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_LONG     = 4
) (
    input  logic         clk,
    input  logic         rstn,
    issue_ctrl_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t    state_reg,       state_next;
    logic [2:0] cnt_reg,        cnt_next;
    logic      br_inflight_reg, br_inflight_next;
    reg_addr_t last_dd_reg,     last_dd_next;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic redirect;
    logic ds_pend, dt_pend, dd_pend, long_full;
    logic ds_match, dt_match;
    logic raw_hold;
    logic stall;
    logic issue;
    logic long_issue;

    // Output-process results
    logic      dec_ready;
    logic      issue_valid;
    ope_t      issue_ope;
    reg_addr_t issue_dd;
    logic      fwd_ds_sel;
    logic      fwd_dt_sel;
    logic      redirect_valid;
    pc_t       redirect_addr;
    logic      flush;

    // The ALU keeps b_is_hazard high across ops it does not recognise, so
    // the flag only means "redirect" when the op in the ALU is a branch we
    // issued last cycle.
    assign redirect = rstn & br_inflight_reg & bus.alu_b_is_hazard;

    // Source read of the register the ALU is producing right now.
    assign ds_match = bus.dec_uses_ds & (bus.dec_ds != '0) & (bus.dec_ds == last_dd_reg);
    assign dt_match = bus.dec_uses_dt & (bus.dec_dt != '0) & (bus.dec_dt == last_dd_reg);

`ifdef ISSUE_FWD_EN
    assign raw_hold = 1'b0;
`else
    // Without the bypass the value is only in the register file one cycle
    // later; the resulting bubble clears last_dd so the hold lasts one cycle.
    assign raw_hold = ds_match | dt_match;
`endif

    assign stall = ~rstn
                 | (state_reg == ST_FLUSH)
                 | redirect
                 | (bus.dec_uses_ds & ds_pend)
                 | (bus.dec_uses_dt & dt_pend)
                 | ((bus.dec_dd != '0) & dd_pend)
                 | (bus.dec_long & long_full)
                 | raw_hold;

    assign issue      = bus.dec_valid & ~stall;
    assign long_issue = issue & bus.dec_long;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    scoreboard #(
        .MAX_LONG (MAX_LONG)
    ) u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .long_issue (long_issue),
        .long_dd    (bus.dec_dd),
        .done_valid (bus.done_valid),
        .done_addr  (bus.done_addr),
        .ds_addr    (bus.dec_ds),
        .dt_addr    (bus.dec_dt),
        .dd_addr    (bus.dec_dd),
        .ds_pend    (ds_pend),
        .dt_pend    (dt_pend),
        .dd_pend    (dd_pend),
        .long_full  (long_full)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (redirect) begin
                    state_next = ST_FLUSH;
                    cnt_next   = 3'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                // The cycle that sees a count of 1 is the last held cycle.
                if (cnt_reg <= 3'd1) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg - 3'd1;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        dec_ready      = ~stall;
        issue_valid    = issue;
        issue_ope      = OPE_BUBBLE;
        issue_dd       = '0;
        fwd_ds_sel     = 1'b0;
        fwd_dt_sel     = 1'b0;
        redirect_valid = redirect;
        redirect_addr  = '0;
        flush          = 1'b0;

        if (issue) begin
            issue_ope = bus.dec_ope;
            issue_dd  = bus.dec_dd;
        end

        if (redirect) begin
            redirect_addr = bus.alu_b_addr;
        end

        if (rstn) begin
            flush = (state_reg == ST_FLUSH) | redirect;
`ifdef ISSUE_FWD_EN
            fwd_ds_sel = ds_match;
            fwd_dt_sel = dt_match;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Branch tracking and forwarding source
    // ------------------------------------------------------------------
    always_comb begin
        br_inflight_next = issue & is_alu_branch(bus.dec_ope);
        // Long ops write back through their own unit, so only a non-long
        // issue leaves a result in the ALU result register.
        last_dd_next     = (issue & ~bus.dec_long) ? bus.dec_dd : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            br_inflight_reg <= 1'b0;
            last_dd_reg     <= '0;
        end else begin
            br_inflight_reg <= br_inflight_next;
            last_dd_reg     <= last_dd_next;
        end
    end

    // ------------------------------------------------------------------
    // Drive the interface
    // ------------------------------------------------------------------
    assign bus.dec_ready      = dec_ready;
    assign bus.issue_valid    = issue_valid;
    assign bus.issue_ope      = issue_ope;
    assign bus.issue_dd       = issue_dd;
    assign bus.fwd_ds_sel     = fwd_ds_sel;
    assign bus.fwd_dt_sel     = fwd_dt_sel;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_addr  = redirect_addr;
    assign bus.flush          = flush;

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

In-order issue controller between decode and the single-cycle integer ALU. It sequences one instruction per cycle into the ALU and holds RAW/WAW hazards against long-latency units (load, FPU) using a 64-entry scoreboard. It steers operand forwarding from the ALU result register and converts resolved ALU branches into a redirect-and-flush sequence. It also emits clean bubbles so stale ALU branch/writeback state never leaks.

## Interface
- `FLUSH_CYCLES`, default 1: cycles decode is held after a redirect (1..7).
- `MAX_LONG`, default 4: maximum outstanding long-latency ops (1..15).

- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `dec_valid` in 1: decode holds an instruction.
- `dec_ope` in 6: opcode.
- `dec_ds`, `dec_dt`, `dec_dd` in 6 each: source and destination register addresses. Address 0 means none.
- `dec_uses_ds`, `dec_uses_dt` in 1 each: source actually read.
- `dec_long` in 1: op executes in a long-latency unit.
- `dec_ready` out 1: instruction consumed this cycle.
- `issue_valid` out 1: valid instruction presented to the ALU / long units.
- `issue_ope` out 6: opcode to the ALU. Bubble value is 6'b000010 (J).
- `issue_dd` out 6: destination. 0 on bubble.
- `fwd_ds_sel`, `fwd_dt_sel` out 1 each: 1 selects the ALU result register instead of the register file.
- `alu_b_is_hazard` in 1: ALU taken-branch flag (registered in the ALU).
- `alu_b_addr` in 14: ALU branch target.
- `done_valid` in 1: long-latency unit writeback.
- `done_addr` in 6: register written by that writeback.
- `redirect_valid` out 1: fetch redirect pulse.
- `redirect_addr` out 14: redirect target.
- `flush` out 1: decode/fetch must drop their contents.

## Operation
- **States:** RUN, FLUSH. FLUSH has a 3-bit down-counter.
- **Scoreboard:** 64-bit `pend`, plus a long counter `lcnt`.
  - Issue of a `dec_long` op with dd≠0 sets `pend[dd]`.
  - `done_valid` clears `pend[done_addr]`.
  - Set and clear of the same address in the same cycle: set wins.
  - `lcnt` increments on long issue and decrements on done. Both together leave it unchanged.
  - `pend[0]` is never set.
- **Branch tracking:** `br_inflight` is set when the issued op is JR 001010, JALR 001110, BEQ 010010 or BLE 011010; otherwise it is cleared.
- **Redirect:** `redirect_valid = br_inflight & alu_b_is_hazard`.
  - Because the ALU holds `b_is_hazard` across unknown ops, the raw flag is never used without `br_inflight`.
- **Stall:** `dec_ready = 0` when any of the following holds:
  - `rstn` = 0
  - state is FLUSH
  - redirect this cycle
  - `dec_uses_ds & pend[ds]`
  - `dec_uses_dt & pend[dt]`
  - `dd≠0 & pend[dd]` (WAW)
  - `dec_long & lcnt==MAX_LONG`
- **Issue:** `issue_valid = dec_valid & dec_ready`. Otherwise outputs are bubble: ope=000010, dd=0.
- **Forwarding:** `last_dd` holds the dd of the last issued non-long op, or 0 after a bubble or long op. `fwd_ds_sel = dec_uses_ds & ds≠0 & ds==last_dd`; `fwd_dt_sel` likewise for dt.
- **Redirect cycle:**
  - `flush` = 1, bubble issued, the decode entry is discarded.
  - `redirect_addr = alu_b_addr`.
  - Next state is FLUSH with counter = `FLUSH_CYCLES`.
- **FLUSH state:** `flush` = 1, bubble issued, counter decrements each cycle. At 1 the state returns to RUN.
  - `done_valid` is still honoured during FLUSH.
- **Reset mid-operation:** state RUN, `pend`/`lcnt`/`br_inflight`/`last_dd` cleared. In-flight long results arriving after reset are ignored (clear of a 0 bit).

## Timing
- All outputs are combinational from registered state plus current inputs. No added latency: decode→ALU issue happens in the same cycle.
- Reset values (`rstn`=0 and the cycle after):
  - `dec_ready`=0, `issue_valid`=0, `issue_ope`=000010, `issue_dd`=0
  - `fwd_*`=0, `redirect_valid`=0, `redirect_addr`=0, `flush`=0
- Branch resolution: the branch issues in cycle N and the redirect is asserted in N+1. Decode is held for N+2..N+1+`FLUSH_CYCLES`. The earliest next issue is N+2+`FLUSH_CYCLES`.
- Long-latency dependence: a dependant issues in the same cycle `done_valid` is seen, because the clear is visible combinationally via bypass of `pend`.

## Configuration
- `ISSUE_FWD_EN` defined: forwarding as above.
- `ISSUE_FWD_EN` undefined:
  - `fwd_*` are tied 0.
  - A RAW match against `last_dd` adds a stall condition, giving exactly one bubble.
  - `last_dd` is cleared by that bubble.

## Structure
- Shared package holds:
  - the opcode constants (J, JR, JALR, BEQ, BLE, bubble)
  - register address width 6
  - PC width 14
  - the state enum
- One sub-module, `scoreboard`: `pend` vector, `lcnt`, set/clear priority, combinational lookup ports for ds/dt/dd with done-bypass.

## Test plan
- ADD r3←r1,r2 then ADD r4←r3,r3 back-to-back → both issue consecutively, second has `fwd_ds_sel`=`fwd_dt_sel`=1. With `ISSUE_FWD_EN` off, one bubble (ope 000010) between them.
- Long op dd=5, then ADD reading r5 → `dec_ready`=0 until `done_valid` with `done_addr`=5, and the ADD issues in that same cycle.
- BEQ issued at N with `alu_b_is_hazard`=1, `alu_b_addr`=0x0123 at N+1 → `redirect_valid`=1, `redirect_addr`=0x0123, `flush`=1 for N+1..N+2 (`FLUSH_CYCLES`=1), next issue at N+3.
- ADD issued while `alu_b_is_hazard` is stale 1 → no redirect.
- Five long ops with `MAX_LONG`=4 and no done → fifth stalls. A done releases it the same cycle.
- `rstn` low during FLUSH with 3 pending regs → all outputs reach reset values, and the first post-reset instruction reading those regs issues without stall.
